// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its round-robin picker.
package fifo_arb_pkg;

    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;
    localparam int DEF_DEPTH = 8;
    localparam int OCC_W     = $clog2(DEF_DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // First set bit of valid at or after ptr, scanning cyclically over the low n bits.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] onehot;
        logic               found;
        int                 idx;
        onehot = '0;
        found  = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if ((k < n) && !found && valid[idx[IDX_W-1:0]]) begin
                onehot[idx[IDX_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin selector: valid vector plus start pointer in, one-hot and index out.
module fifo_rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [MAX_REQ-1:0] w_pick;

    assign w_valid_ext = MAX_REQ'(i_valid);
    assign w_pick      = rr_pick(w_valid_ext, i_ptr, NUM_REQ);
    assign o_onehot    = w_pick[NUM_REQ-1:0];
    assign o_any       = |w_pick;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port; a local credit counter keeps writes off a full FIFO.
// Handshake: a producer beat transfers in any cycle where its req_valid and req_ready are both high.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ-1:0]         i_req_last,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_fifo_rd_ok,
    input  logic                       i_fifo_full,
    output logic                       o_fifo_wr,
    output logic [DATA_W-1:0]          o_fifo_data,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(DEPTH+1)-1:0] o_occ,
    output logic                       o_ovf_err,
    output state_t                     o_dbg_state,
    output logic [IDX_W-1:0]           o_dbg_rr_ptr
);

    localparam int                    OCC_WIDTH = $clog2(DEPTH + 1);
    localparam int                    BEAT_W    = $clog2(MAX_BURST + 1);
    localparam logic [OCC_WIDTH-1:0]  OCC_FULL  = OCC_WIDTH'(DEPTH);
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_REQ - 1);

    state_t                r_state, w_next_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [IDX_W-1:0]      r_gnt_idx;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [OCC_WIDTH-1:0]  r_occ;
    logic                  r_fifo_wr;
    logic [DATA_W-1:0]     r_fifo_data;
    logic                  r_ovf_err;

    logic [NUM_REQ-1:0]    w_pick_onehot;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    logic                  w_gnt_valid;
    logic                  w_gnt_last;
    logic [DATA_W-1:0]     w_gnt_data;
    logic                  w_credit;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_accept;
    logic                  w_release;

    fifo_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_valid  (i_req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_gnt_valid = |(i_req_valid & r_gnt);
    assign w_gnt_last  = |(i_req_last & r_gnt);

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) w_gnt_data = i_req_data[i*DATA_W +: DATA_W];
        end
    end

    // A read this cycle frees a slot, so a beat may enter even at full occupancy.
    assign w_credit  = (r_occ < OCC_FULL) || i_fifo_rd_ok;
    assign w_accept  = |(i_req_valid & w_ready);
    assign w_release = (r_state == BURST) &&
                       (!w_gnt_valid || (w_accept && (w_gnt_last || (r_beat_cnt == BEAT_LAST))));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_next_state = BURST;
            BURST:   if (w_release)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ready = '0;
        if ((r_state == BURST) && w_credit) w_ready = r_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_occ       <= '0;
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_fifo_wr <= w_accept;
            if (w_accept) r_fifo_data <= w_gnt_data;
            r_ovf_err <= r_ovf_err | (r_fifo_wr & i_fifo_full & ~i_fifo_rd_ok);

            if (w_accept && !i_fifo_rd_ok)
                r_occ <= r_occ + OCC_WIDTH'(1);
            else if (!w_accept && i_fifo_rd_ok && (r_occ != '0))
                r_occ <= r_occ - OCC_WIDTH'(1);

            if ((r_state == IDLE) && w_pick_any) begin
                r_gnt      <= w_pick_onehot;
                r_gnt_idx  <= w_pick_idx;
                r_beat_cnt <= '0;
            end else if (w_release) begin
                r_gnt    <= '0;
                r_rr_ptr <= (r_gnt_idx == IDX_LAST) ? '0 : r_gnt_idx + IDX_W'(1);
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    assign o_req_ready  = w_ready;
    assign o_fifo_wr    = r_fifo_wr;
    assign o_fifo_data  = r_fifo_data;
    assign o_gnt        = r_gnt;
    assign o_occ        = r_occ;
    assign o_ovf_err    = r_ovf_err;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule
